// File: rtl/demux_sink_2ch.sv
// ============================================================================
// demux_sink_2ch
// ----------------------------------------------------------------------------
// Downstream consumer of the 2-line demultiplexer. A load strobe captures the
// selected demux output into one of two per-channel FIFOs. Both FIFOs are
// drained onto one valid/ready stream with round-robin arbitration, which
// decouples bus write timing from consumer back-pressure.
//
// Parameters
//   WIDTH      data width of each channel and of the output stream
//   DEPTH      entries per channel FIFO (power of 2, >= 2)
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   clr        asynchronous active-high reset
//   in0, in1   demux outputs 0 and 1
//   sel        demux select: 0 = channel 0, 1 = channel 1
//   load       write strobe; channel sel captures its input at the edge
//   full0/1    channel FIFO holds DEPTH entries
//   ovf        sticky overflow flag (a push into a full channel was dropped)
//   out_data   head entry of the granted channel (0 when nothing is stored)
//   out_ch     channel that out_data belongs to
//   out_valid  at least one channel is non-empty
//   out_ready  consumer accepts the word when high together with out_valid
// ============================================================================
module demux_sink_2ch #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    input  logic             load,
    output logic             full0,
    output logic             full1,
    output logic             ovf,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ch,
    output logic             out_valid,
    input  logic             out_ready
);

    // Pointer width indexes DEPTH entries exactly, so increments wrap
    // modulo DEPTH for free. Counts need one extra bit to represent DEPTH.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    CNT_FULL  = CW'(DEPTH);
    localparam logic [PW-1:0]    PTR_ZERO  = PW'(0);
    localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
    localparam logic [WIDTH-1:0] DATA_ZERO = WIDTH'(0);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q  [2][DEPTH];
    logic [CW-1:0]    cnt_q  [2];
    logic [CW-1:0]    cnt_d  [2];
    logic [PW-1:0]    wptr_q [2];
    logic [PW-1:0]    wptr_d [2];
    logic [PW-1:0]    rptr_q [2];
    logic [PW-1:0]    rptr_d [2];
    logic             rr_q;
    logic             rr_d;
    logic             ovf_q;
    logic             ovf_d;

    // ------------------------------------------------------------------------
    // Per-channel status and handshake decode (bit index = channel)
    // ------------------------------------------------------------------------
    logic [1:0]       nonempty_s;
    logic [1:0]       full_s;
    logic [1:0]       push_s;
    logic [1:0]       pop_s;
    logic [1:0]       accept_s;
    logic [1:0]       drop_s;
    logic             grant_s;
    logic             valid_s;
    logic             pop_any_s;
    logic [WIDTH-1:0] wdata_s;

    // Empty/full status straight from the registered counts.
    always_comb begin
        nonempty_s = 2'b00;
        full_s     = 2'b00;
        for (int c = 0; c < 2; c++) begin
            nonempty_s[c] = (cnt_q[c] != CNT_ZERO);
            full_s[c]     = (cnt_q[c] == CNT_FULL);
        end
    end

    // Round-robin grant: a lone non-empty channel always wins; when both hold
    // data the channel opposite to the last one served wins.
    always_comb begin
        grant_s = 1'b0;
        case (nonempty_s)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~rr_q;
            default: grant_s = 1'b0;
        endcase
    end

    // Handshake, push decode and overflow detection.
    always_comb begin
        valid_s   = |nonempty_s;
        pop_any_s = valid_s & out_ready;
        pop_s     = {pop_any_s & grant_s, pop_any_s & ~grant_s};
        push_s    = {load & sel, load & ~sel};
        wdata_s   = sel ? in1 : in0;
        // A push into a full channel still fits when that channel's head
        // leaves in the same cycle: the freed slot is the one written.
        accept_s  = push_s & (~full_s | pop_s);
        drop_s    = push_s & full_s & ~pop_s;
    end

    // Next-state for counts, pointers, arbitration memory and overflow.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            case ({accept_s[c], pop_s[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + CNT_ONE;
                2'b01:   cnt_d[c] = cnt_q[c] - CNT_ONE;
                default: cnt_d[c] = cnt_q[c];
            endcase
            if (accept_s[c]) begin
                wptr_d[c] = wptr_q[c] + PTR_ONE;
            end else begin
                wptr_d[c] = wptr_q[c];
            end
            if (pop_s[c]) begin
                rptr_d[c] = rptr_q[c] + PTR_ONE;
            end else begin
                rptr_d[c] = rptr_q[c];
            end
        end
        if (pop_any_s) begin
            rr_d = grant_s;
        end else begin
            rr_d = rr_q;
        end
        ovf_d = ovf_q | (|drop_s);
    end

    // Control state register; clr discards everything immediately.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int c = 0; c < 2; c++) begin
                cnt_q[c]  <= CNT_ZERO;
                wptr_q[c] <= PTR_ZERO;
                rptr_q[c] <= PTR_ZERO;
            end
            rr_q  <= 1'b1;
            ovf_q <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                cnt_q[c]  <= cnt_d[c];
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
            end
            rr_q  <= rr_d;
            ovf_q <= ovf_d;
        end
    end

    // FIFO storage; cleared on clr so no stale word can ever be observed.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int c = 0; c < 2; c++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[c][e] <= DATA_ZERO;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (accept_s[c]) begin
                    mem_q[c][wptr_q[c]] <= wdata_s;
                end else begin
                    mem_q[c][wptr_q[c]] <= mem_q[c][wptr_q[c]];
                end
            end
        end
    end

    // Output stream, driven only from stored state (no path from in0/in1).
    always_comb begin
        out_valid = valid_s;
        out_ch    = grant_s;
        if (valid_s) begin
            out_data = mem_q[grant_s][rptr_q[grant_s]];
        end else begin
            out_data = DATA_ZERO;
        end
        full0 = full_s[0];
        full1 = full_s[1];
        ovf   = ovf_q;
    end

endmodule
